// File: rtl/stream_ser_if.sv
// ----------------------------------------------------------------------------
// stream_ser_if
//   Bundles the two req/ack links around the serialiser: the wide word link
//   coming from the upstream FIFO and the narrow beat link going out.
//
//   Handshake rule (both links): a transfer happens on a posedge where the
//   sender's req and the receiver's ack are both high. The sender keeps req
//   and its data (plus last_out on the beat link) stable until that edge. An
//   ack while req is low means nothing.
//
//   Parameters: dw = word width, sw = beat width.
//   Signals:
//     d_in     [dw]  word from upstream
//     req_in         upstream word valid
//     ack_in         serialiser can take the word this cycle
//     d_out    [sw]  current beat
//     req_out        beat valid
//     last_out       current beat is the final one of its word
//     ack_out        downstream consumes the beat this cycle
//   Modports: master = serialiser view, slave = environment view.
// ----------------------------------------------------------------------------
interface stream_ser_if #(
    parameter int dw = 32,
    parameter int sw = 8
);
    logic [dw-1:0] d_in;
    logic          req_in;
    logic          ack_in;
    logic [sw-1:0] d_out;
    logic          req_out;
    logic          last_out;
    logic          ack_out;

    modport master (
        input  d_in, req_in, ack_out,
        output ack_in, d_out, req_out, last_out
    );

    modport slave (
        output d_in, req_in, ack_out,
        input  ack_in, d_out, req_out, last_out
    );
endinterface

// File: rtl/stream_ser.sv
// ----------------------------------------------------------------------------
// stream_ser
//   Takes dw-bit words from a FIFO output and sends each as n = dw/sw beats
//   of sw bits on a req/ack link, flagging the final beat with last_out.
//   A new word is taken on the same edge the last beat of the previous word
//   leaves, so a steady stream runs at n beats per word with no idle cycle.
//
//   Build option: define STREAM_SER_MSB_FIRST_EN to send the most significant
//   beat first; default sends the least significant beat first. Handshake,
//   last_out and timing are the same either way.
//
//   Ports:
//     clk        clock, posedge
//     rst        synchronous reset, active-high
//     bus        stream_ser_if.master (word in / beat out links)
//     dbg_state  1 while a word is being sent (FSM state S_BUSY)
// ----------------------------------------------------------------------------
module stream_ser #(
    parameter int dw = 32,
    parameter int sw = 8
) (
    input  logic         clk,
    input  logic         rst,
    stream_ser_if.master bus,
    output logic         dbg_state
);
    localparam int n  = dw / sw;
    localparam int cw = (n > 1) ? $clog2(n) : 1;
    localparam int iw = (dw > 1) ? $clog2(dw) : 1;

    if ((dw % sw) != 0 || (dw / sw) < 2) begin : g_bad_param
        $error("stream_ser: dw must be a multiple of sw with dw/sw >= 2");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [dw-1:0] hold,  hold_nxt;
    logic [cw-1:0] cnt,   cnt_nxt;

    logic          busy;
    logic          beat_last;
    logic          beat_take;
    logic          word_take;
    logic [iw-1:0] base;

    assign busy      = (state == S_BUSY);
    assign beat_last = busy && (cnt == cw'(n - 1));
    assign beat_take = busy && bus.ack_out;
    // Ready when empty, or when the word in flight finishes on this edge.
    assign word_take = bus.req_in && bus.ack_in;

    always_comb begin
        bus.ack_in   = ~busy | (beat_take & beat_last);
        bus.req_out  = busy;
        bus.last_out = beat_last;
`ifdef STREAM_SER_MSB_FIRST_EN
        // Beat k starts at bit dw-sw-k*sw, i.e. hold[dw-1-k*sw -: sw].
        base = iw'(dw - sw) - iw'(cnt) * iw'(sw);
`else
        base = iw'(cnt) * iw'(sw);
`endif
        bus.d_out    = hold[base +: sw];
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        cnt_nxt   = cnt;
        if (beat_take) begin
            if (beat_last) begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end else begin
                cnt_nxt = cnt + cw'(1);
            end
        end
        // A word accepted on the last-beat edge overrides the return to idle.
        if (word_take) begin
            hold_nxt  = bus.d_in;
            cnt_nxt   = '0;
            state_nxt = S_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            hold  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign dbg_state = busy;
endmodule
